// File: rtl/data_mem_master.sv
// data_mem_master: valid/ready access engine for a word-addressed data memory
// with combinational read and edge-triggered write.
// Ports:
//   clk, rst                             clock and synchronous active-high reset
//   req_valid/ready, req_we/addr/len     burst request (load or store)
//   wr_valid/ready, wr_data              store data beats
//   rsp_valid/ready, rsp_data/last/err   response beats
//   mem_we, mem_a, mem_di, mem_rd        memory pins
module data_mem_master #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int MEM_DEPTH  = 4,
   parameter int LEN_W      = $clog2(MEM_DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [LEN_W-1:0]      req_len,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  rsp_last,
   output logic                  rsp_err,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_a,
   output logic [DATA_WIDTH-1:0] mem_di,
   input  logic [DATA_WIDTH-1:0] mem_rd
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] WRITE = 3'd1;
   localparam logic [2:0] READ  = 3'd2;
   localparam logic [2:0] RDATA = 3'd3;
   localparam logic [2:0] RESP  = 3'd4;

   localparam logic [ADDR_WIDTH-1:0] STEP  = ADDR_WIDTH'(4);
   localparam logic [LEN_W-1:0]      ONE   = LEN_W'(1);
   localparam logic [ADDR_WIDTH:0]   DEPTH = (ADDR_WIDTH+1)'(MEM_DEPTH);

   logic [2:0]            state;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [LEN_W-1:0]      cnt_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  err_q;

   // One extra bit so index + length can never wrap.
   logic [ADDR_WIDTH:0] end_idx;
   logic                req_bad;

   assign end_idx = (ADDR_WIDTH+1)'(req_addr[ADDR_WIDTH-1:2])
                  + (ADDR_WIDTH+1)'(req_len);

   assign req_bad = (req_addr[1:0] != 2'b00)
                  | (req_len == '0)
                  | (end_idx > DEPTH);

   logic last_rd;
   assign last_rd = (cnt_q == ONE);

   assign req_ready = (state == IDLE);
   assign wr_ready  = (state == WRITE);
   assign rsp_valid = (state == RDATA) | (state == RESP);
   assign rsp_last  = (state == RESP) | ((state == RDATA) & last_rd);
   assign rsp_err   = (state == RESP) & err_q;
   assign rsp_data  = data_q;

   assign mem_a  = addr_q;
   // Gate with rst so no write lands on a reset edge mid-burst.
   assign mem_we = (state == WRITE) & wr_valid & ~rst;
   assign mem_di = (state == WRITE) ? wr_data : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         addr_q <= '0;
         cnt_q  <= '0;
         data_q <= '0;
         err_q  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (req_valid) begin
                  if (req_bad) begin
                     state  <= RESP;
                     err_q  <= 1'b1;
                     data_q <= '0;
                  end else begin
                     addr_q <= req_addr;
                     cnt_q  <= req_len;
                     err_q  <= 1'b0;
                     state  <= req_we ? WRITE : READ;
                  end
               end
            end
            WRITE: begin
               if (wr_valid) begin
                  addr_q <= addr_q + STEP;
                  cnt_q  <= cnt_q - ONE;
                  if (last_rd) begin
                     state  <= RESP;
                     data_q <= '0;
                  end
               end
            end
            READ: begin
               data_q <= mem_rd;
               state  <= RDATA;
            end
            RDATA: begin
               if (rsp_ready) begin
                  if (last_rd) begin
                     state  <= IDLE;
                     data_q <= '0;
                  end else begin
                     addr_q <= addr_q + STEP;
                     cnt_q  <= cnt_q - ONE;
                     state  <= READ;
                  end
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state  <= IDLE;
                  err_q  <= 1'b0;
                  data_q <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_master.sv
// tb_data_mem_master: drives directed and random bursts into data_mem_master
// and compares responses and memory contents against a word-array model.
module tb_data_mem_master;

   localparam int DW    = 32;
   localparam int AW    = 32;
   localparam int DEPTH = 4;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid, req_ready, req_we;
   logic [AW-1:0] req_addr;
   logic [LW-1:0] req_len;
   logic          wr_valid, wr_ready;
   logic [DW-1:0] wr_data;
   logic          rsp_valid, rsp_ready, rsp_last, rsp_err;
   logic [DW-1:0] rsp_data;
   logic          mem_we;
   logic [AW-1:0] mem_a;
   logic [DW-1:0] mem_di, mem_rd;

   always #5 clk = ~clk;

   data_mem_master #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH), .LEN_W(LW)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_len(req_len),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_last(rsp_last), .rsp_err(rsp_err),
      .mem_we(mem_we), .mem_a(mem_a), .mem_di(mem_di), .mem_rd(mem_rd)
   );

   // Target memory and its reference copy.
   logic [DW-1:0] mem     [DEPTH];
   logic [DW-1:0] ref_mem [DEPTH];
   int wr_cnt = 0;

   assign mem_rd = (mem_a < AW'(4*DEPTH)) ? mem[mem_a[3:2]] : '0;

   always @(posedge clk) begin
      if (mem_we) begin
         wr_cnt++;
         if (mem_a < AW'(4*DEPTH)) mem[mem_a[3:2]] <= mem_di;
      end
   end

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic bit model_err(input logic [31:0] a, input int len);
      longint idx;
      idx = longint'(a >> 2);
      return (a[1:0] != 2'b00) || (len == 0) || (idx + len > DEPTH);
   endfunction

   // gap: 0 no gaps, 1 alternate 1/0, 2 random; stall: >=0 fixed, -1 random
   task automatic run_txn(input bit we, input logic [31:0] addr,
                          input int len, input int gap, input int stall);
      bit            err;
      bit            v;
      int            k, n, s, w0, base;
      logic [31:0]   wd[$];
      logic [31:0]   ed[$];
      bit            el[$];
      err  = model_err(addr, len);
      base = int'(addr >> 2);
      w0   = wr_cnt;
      if (err || we) begin
         ed.push_back(32'h0);
         el.push_back(1'b1);
      end else begin
         for (int i = 0; i < len; i++) begin
            ed.push_back(ref_mem[base + i]);
            el.push_back(i == len - 1);
         end
      end
      if (!err && we) begin
         for (int i = 0; i < len; i++) begin
            wd.push_back($urandom);
            ref_mem[base + i] = wd[i];
         end
      end
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_len   = LW'(len);
      #1 check("req_ready", req_ready, 1);
      @(posedge clk);
      if (!err && we) begin
         k = 0;
         n = 0;
         while (k < len && n < 100) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (gap == 0) v = 1'b1;
            else if (gap == 1) v = (n % 2 == 0);
            else v = ($urandom_range(0, 2) != 0);
            wr_valid = v;
            wr_data  = wd[k];
            #1;
            check("wr_ready", wr_ready, 1);
            check("wr_addr", mem_a, addr + 4 * k);
            check("mem_we", mem_we, v);
            if (v) check("mem_di", mem_di, wd[k]);
            @(posedge clk);
            if (v) k++;
            n++;
         end
         if (k < len) check("wr_timeout", k, len);
      end
      foreach (ed[b]) begin
         n = 0;
         do begin
            @(negedge clk);
            req_valid = 1'b0;
            wr_valid  = 1'b0;
            rsp_ready = 1'b0;
            n++;
         end while (!rsp_valid && n < 20);
         check("rsp_valid", rsp_valid, 1);
         check("rsp_lat", n, (b == 0 && (err || we)) ? 1 : 2);
         check("rsp_data", rsp_data, ed[b]);
         check("rsp_last", rsp_last, el[b]);
         check("rsp_err", rsp_err, err);
         if (stall >= 0) s = stall;
         else s = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
         repeat (s) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_valid", rsp_valid, 1);
            check("hold_data", rsp_data, ed[b]);
            check("hold_last", rsp_last, el[b]);
         end
         rsp_ready = 1'b1;
         @(posedge clk);
      end
      @(negedge clk);
      rsp_ready = 1'b0;
      check("idle_ready", req_ready, 1);
      check("idle_valid", rsp_valid, 0);
      check("wr_count", wr_cnt - w0, (err || !we) ? 0 : len);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d[4];
      for (int i = 0; i < DEPTH; i++) begin
         mem[i]     = '0;
         ref_mem[i] = '0;
      end
      rst       = 1'b1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_len   = '0;
      wr_valid  = 1'b0;
      wr_data   = '0;
      rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_req_ready", req_ready, 1);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_last", rsp_last, 0);
      check("rst_rsp_err", rsp_err, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_mem_a", mem_a, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_wr_ready", wr_ready, 0);

      // Store 4 words then read back part of them.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0; req_len = LW'(4);
      @(posedge clk);
      d[0] = 32'h11; d[1] = 32'h22; d[2] = 32'h33; d[3] = 32'h44;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         req_valid = 1'b0;
         wr_valid  = 1'b1;
         wr_data   = d[i];
         #1;
         check("tp_we", mem_we, 1);
         check("tp_addr", mem_a, 32'(4 * i));
         ref_mem[i] = d[i];
         @(posedge clk);
      end
      @(negedge clk);
      wr_valid = 1'b0;
      check("tp_rsp_valid", rsp_valid, 1);
      check("tp_rsp_err", rsp_err, 0);
      check("tp_rsp_last", rsp_last, 1);
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      check("tp_idle", req_ready, 1);

      run_txn(1'b0, 32'h4, 2, 0, 0);
      run_txn(1'b0, 32'h0, 1, 0, 5);
      check("bp_word0", ref_mem[0], 32'h11);

      run_txn(1'b0, 32'h2, 1, 0, 0);
      run_txn(1'b0, 32'h0, 0, 0, 0);
      run_txn(1'b0, 32'h8, 3, 0, 0);
      run_txn(1'b1, 32'h8, 3, 0, 1);
      run_txn(1'b1, 32'h0, 3, 1, 0);

      // Reset in the middle of a 4-word store.
      for (int i = 0; i < 4; i++) d[i] = $urandom;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0; req_len = LW'(4);
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         req_valid = 1'b0;
         wr_valid  = 1'b1;
         wr_data   = d[i];
         ref_mem[i] = d[i];
         @(posedge clk);
      end
      @(negedge clk);
      rst      = 1'b1;
      wr_data  = d[2];
      #1 check("rst_gate_we", mem_we, 0);
      @(posedge clk);
      @(negedge clk);
      rst      = 1'b0;
      wr_valid = 1'b0;
      #1 check("rst_we_low", mem_we, 0);
      check("rst_ready_after", req_ready, 1);
      check("rst_no_rsp", rsp_valid, 0);
      check("rst_mem_a0", mem_a, 0);
      for (int i = 0; i < DEPTH; i++) check("rst_mem", mem[i], ref_mem[i]);

      repeat (60) begin
         bit          rwe;
         logic [31:0] ra;
         int          rl;
         rwe = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) ra = $urandom_range(0, 24);
         else ra = 32'(4 * $urandom_range(0, 4));
         rl = $urandom_range(0, 5);
         run_txn(rwe, ra, rl, 2, -1);
      end

      for (int i = 0; i < DEPTH; i++) check("final_mem", mem[i], ref_mem[i]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/data_mem_master.md
Name: data_mem_master

Overview:
- Initiator-side access engine for the word-addressed data memory (Data_Memory), which has a combinational read and a write on the clock edge when write enable is high.
- Accepts single or burst load/store requests from the control unit over a valid/ready handshake and drives the memory's we/a/di pins.
- Returns read data or a write completion as response beats.
- Rejects misaligned, zero-length and out-of-range requests with an error response; no memory access occurs for a rejected request.

Parameters:
- DATA_WIDTH, 32, width of data words.
- ADDR_WIDTH, 32, width of byte address.
- MEM_DEPTH, 4, number of words in the target memory.
- LEN_W, $clog2(MEM_DEPTH)+1, width of burst length field.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  engine can accept a request.
- req_we  in  1  1 = store burst, 0 = load burst.
- req_addr  in  ADDR_WIDTH  byte address of the first word.
- req_len  in  LEN_W  number of words, 1..MEM_DEPTH.
- wr_valid  in  1  store data beat present.
- wr_ready  out  1  engine accepts a store beat.
- wr_data  in  DATA_WIDTH  store data.
- rsp_valid  out  1  response beat present.
- rsp_ready  in  1  consumer accepts the response beat.
- rsp_data  out  DATA_WIDTH  load data; 0 for store completion and for errors.
- rsp_last  out  1  final beat of the burst.
- rsp_err  out  1  request rejected.
- mem_we  out  1  to the memory write enable.
- mem_a  out  ADDR_WIDTH  to the memory address.
- mem_di  out  DATA_WIDTH  to the memory write data.
- mem_rd  in  DATA_WIDTH  from the memory read data (combinational).

Behaviour:
- States: IDLE, WRITE, READ, RDATA, RESP.
- Reset (rst=1 at a clk edge): state=IDLE; address register, count and rsp_data cleared to 0; rsp_valid/rsp_last/rsp_err=0.
- mem_we is gated by !rst combinationally, so no write occurs on any edge where rst=1.
- Reset mid-burst abandons the burst. Words already written stay written; no response is issued.
- IDLE: req_ready=1, all other handshake outputs 0.
- Request acceptance happens when req_valid & req_ready. Word index = req_addr[ADDR_WIDTH-1:2].
- Error check at acceptance. The request is in error if any of the following holds:
  - req_addr[1:0] != 0;
  - req_len == 0;
  - index + req_len > MEM_DEPTH (computed with enough width that it cannot overflow).
- On error, go to RESP with rsp_err=1, rsp_data=0, rsp_last=1.
- Otherwise latch the address and count = req_len, then go to WRITE if req_we=1, else READ.
- WRITE: wr_ready=1, mem_a = address register.
  - mem_di = wr_data; mem_we = wr_valid.
  - Each accepted beat is written on that same clk edge. Then address += 4 and count -= 1.
  - When count reaches 0, go to RESP with rsp_err=0, rsp_last=1, rsp_data=0.
  - Outside WRITE, mem_we=0 and mem_di=0.
- READ: one cycle. mem_a = address register; rsp_data <= mem_rd on the edge; go to RDATA.
- RDATA: rsp_valid=1; rsp_data is stable; rsp_last=(count==1).
  - rsp_ready=1 with count==1: go to IDLE.
  - rsp_ready=1 otherwise: address += 4, count -= 1, back to READ.
  - rsp_ready=0: hold all outputs.
  - Load throughput is 1 word per 2 cycles minimum.
- RESP: rsp_valid=1, held until rsp_ready=1, then go to IDLE.
- mem_a equals the address register in every state (0 after reset).
- req_ready=0 in every state except IDLE. Request inputs are ignored outside IDLE.
- The wr_valid/wr_data pair is ignored outside WRITE.
- Latency:
  - load: request accept to first rsp_valid = 2 cycles;
  - store: final write edge to rsp_valid = 1 cycle.

Test Plan:
- Reset, then store: req_we=1, addr=0x0, len=4, wr_data 0x11,0x22,0x33,0x44 sent back-to-back. Required: mem_we high for 4 cycles with mem_a 0x0,0x4,0x8,0xC; then one rsp_valid with rsp_err=0, rsp_last=1.
- Load after the above: addr=0x4, len=2, rsp_ready=1. Required: rsp_data 0x22 then 0x33; rsp_last only on the second beat; each beat appears 2 cycles after the previous.
- Backpressure: load addr=0x0, len=1 with rsp_ready=0 for 5 cycles. Required: rsp_valid and rsp_data=0x11 held stable for all 5 cycles; IDLE is entered the cycle after rsp_ready=1.
- Errors: each of addr=0x2/len=1, addr=0x0/len=0 and addr=0x8/len=3 gives rsp_err=1 and rsp_data=0, and mem_we is never asserted.
- Store gaps: len=3 with wr_valid toggling 1,0,1,0,1. Required: exactly 3 writes, to 0x0,0x4,0x8; the address does not advance on idle cycles.
- Reset mid-store: assert rst after 2 of 4 beats. Required:
  - words 0 and 1 are updated and words 2 and 3 are unchanged;
  - req_ready=1 the cycle after rst drops;
  - mem_we=0 during rst.
